// File: rtl/ct_decoder_if.sv
// ct_decoder_if: ciphertext load port, control and coefficient write bus
// for the ciphertext decoder. The master side is the system that loads bytes
// and consumes coefficients; the slave side is ct_decoder.
interface ct_decoder_if;
  logic        start;
  logic        done;
  logic [7:0]  ct_dia;
  logic        ct_wea;
  logic [10:0] ct_addra;
  logic        coef_we;
  logic        coef_sel;
  logic [8:0]  coef_addr;
  logic [13:0] coef_do;
  logic        err;

  modport master (
    output start, ct_dia, ct_wea, ct_addra,
    input  done, coef_we, coef_sel, coef_addr, coef_do, err
  );

  modport slave (
    input  start, ct_dia, ct_wea, ct_addra,
    output done, coef_we, coef_sel, coef_addr, coef_do, err
  );
endinterface

// File: rtl/ct_decoder.sv
// ct_decoder: NewHope-512 ciphertext unpacker.
// Bytes are loaded into a 1088x8 RAM, then on start the 896-byte u part is
// unpacked into 512 14-bit coefficients (7 bytes -> 4 coefficients) and the
// 192-byte v part into 512 decompressed 3-bit coefficients (3 bytes -> 8).
// Every group takes 12 cycles: a fetch phase (reads plus one cycle of RAM
// latency) followed by one emit cycle per coefficient.
// Optional feature: define CT_RANGE_CHECK_EN to build a sticky err flag that
// is raised by any emitted u coefficient >= Q; otherwise err is tied low.
module ct_decoder #(
  parameter int Q        = 12289,
  parameter int N        = 512,
  parameter int CT_BYTES = 1088
) (
  input  logic         clk,
  input  logic         rst,
  ct_decoder_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_U = 3'd1;
  localparam logic [2:0] S_EMIT_U  = 3'd2;
  localparam logic [2:0] S_FETCH_V = 3'd3;
  localparam logic [2:0] S_EMIT_V  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [6:0] U_LAST_GRP = 7'(N / 4 - 1);
  localparam logic [6:0] V_LAST_GRP = 7'(N / 8 - 1);

  logic [2:0]  state;
  logic [2:0]  k;
  logic [6:0]  grp;
  logic [10:0] ptr;
  logic [55:0] sr;
  logic [7:0]  rd_q;
  logic [7:0]  ram [0:CT_BYTES-1];

  logic        idle_like;
  logic        rd_en;
  logic        cap_en;
  logic [23:0] vb;
  logic [2:0]  v_r;
  logic [16:0] v_prod;
  logic [13:0] u_coef;

  // Control decode: write window, RAM read issue and shift-register capture.
  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
    rd_en     = ((state == S_FETCH_U) && (k != 3'd7)) ||
                ((state == S_FETCH_V) && (k < 3'd3));
    cap_en    = ((state == S_FETCH_U) || (state == S_FETCH_V)) && (k != 3'd0);
  end

  // Byte RAM: writes only while not decoding, registered read.
  always_ff @(posedge clk) begin
    if (idle_like && bus.ct_wea && (bus.ct_addra < 11'(CT_BYTES)))
      ram[bus.ct_addra] <= bus.ct_dia;
    if (rd_en)
      rd_q <= ram[ptr];
  end

  // Bytes shift in from the top, so after a u fetch b0 sits at [7:0] and the
  // register reads as one little-endian 56-bit word; after a v fetch the three
  // bytes occupy [55:32].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sr <= '0;
    else if (cap_en)
      sr <= {rd_q, sr[55:8]};
  end

  // Main sequencer: group/phase counters and the running byte pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      grp   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state <= S_FETCH_U;
            k     <= '0;
            grp   <= '0;
            ptr   <= '0;
          end
        end
        S_FETCH_U: begin
          if (rd_en) ptr <= ptr + 11'd1;
          if (k == 3'd7) begin
            state <= S_EMIT_U;
            k     <= '0;
          end else begin
            k <= k + 3'd1;
          end
        end
        S_EMIT_U: begin
          if (k == 3'd3) begin
            k <= '0;
            if (grp == U_LAST_GRP) begin
              grp   <= '0;
              state <= S_FETCH_V;
            end else begin
              grp   <= grp + 7'd1;
              state <= S_FETCH_U;
            end
          end else begin
            k <= k + 3'd1;
          end
        end
        S_FETCH_V: begin
          if (rd_en) ptr <= ptr + 11'd1;
          if (k == 3'd3) begin
            state <= S_EMIT_V;
            k     <= '0;
          end else begin
            k <= k + 3'd1;
          end
        end
        S_EMIT_V: begin
          if (k == 3'd7) begin
            k <= '0;
            if (grp == V_LAST_GRP) begin
              state <= S_DONE;
            end else begin
              grp   <= grp + 7'd1;
              state <= S_FETCH_V;
            end
          end else begin
            k <= k + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Coefficient datapath: 14-bit u slice and v decompression (r*Q + 4) >> 3.
  always_comb begin
    vb = sr[55:32];
    case (k[1:0])
      2'd0:    u_coef = sr[13:0];
      2'd1:    u_coef = sr[27:14];
      2'd2:    u_coef = sr[41:28];
      default: u_coef = sr[55:42];
    endcase
    case (k)
      3'd0:    v_r = vb[2:0];
      3'd1:    v_r = vb[5:3];
      3'd2:    v_r = vb[8:6];
      3'd3:    v_r = vb[11:9];
      3'd4:    v_r = vb[14:12];
      3'd5:    v_r = vb[17:15];
      3'd6:    v_r = vb[20:18];
      default: v_r = vb[23:21];
    endcase
    v_prod = {14'd0, v_r} * 17'(Q) + 17'd4;
  end

  // Output bus: driven straight from state so reset silences it at once.
  always_comb begin
    bus.done      = (state == S_DONE);
    bus.coef_we   = (state == S_EMIT_U) || (state == S_EMIT_V);
    bus.coef_sel  = (state == S_EMIT_V);
    bus.coef_addr = '0;
    bus.coef_do   = '0;
    if (state == S_EMIT_U) begin
      bus.coef_addr = {grp, k[1:0]};
      bus.coef_do   = u_coef;
    end else if (state == S_EMIT_V) begin
      bus.coef_addr = {grp[5:0], k};
      bus.coef_do   = v_prod[16:3];
    end
  end

`ifdef CT_RANGE_CHECK_EN
  logic err_q;

  // Sticky range flag: cleared by an accepted start, set by any u >= Q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_q <= 1'b0;
    else if (idle_like && bus.start)
      err_q <= 1'b0;
    else if ((state == S_EMIT_U) && (u_coef >= 14'(Q)))
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
